// File: rtl/wb_commit.sv
// Writeback/commit stage: registers one mem-stage instruction, retires it
// to the register file or raises a trap, then discards a fixed kill window.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   mem_valid / mem_ready           capture handshake from the mem stage
//   mem_pc .. mem_csr_wdata         instruction bundle from the mem stage
//   csr_addr/csr_write/csr_wdata    CSR access port (request)
//   csr_error/csr_rdata             CSR access port (response)
//   wb_valid/wb_exc/wb_exc_cause    retire / trap report to the CSR block
//   wb_pc/wb_data                   pc and tval of the committing entry
//   rf_we/rf_rd/rf_wdata            register file write port
//   flush                           kill younger pipeline state
module wb_commit #(
    parameter int KILL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [29:0] mem_pc,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        mem_exc,
    input  logic [3:0]  mem_exc_cause,
    input  logic [31:0] mem_tval,
    input  logic        mem_csr_en,
    input  logic [1:0]  mem_csr_op,
    input  logic [11:0] mem_csr_addr,
    input  logic [31:0] mem_csr_wdata,
    output logic [11:0] csr_addr,
    output logic [1:0]  csr_write,
    output logic [31:0] csr_wdata,
    input  logic        csr_error,
    input  logic [31:0] csr_rdata,
    output logic        wb_valid,
    output logic        wb_exc,
    output logic [3:0]  wb_exc_cause,
    output logic [29:0] wb_pc,
    output logic [31:0] wb_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        flush
);

    localparam logic [3:0] ILLEGAL = 4'd2;
    localparam logic [3:0] KILL_N  = 4'(KILL_CYCLES);

    typedef enum logic {
        RUN,
        KILL
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        valid_q;
    logic [29:0] pc_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic [3:0]  cause_q;
    logic [31:0] tval_q;
    logic        csr_en_q;
    logic [1:0]  csr_op_q;
    logic [11:0] csr_addr_q;
    logic [31:0] csr_wdata_q;

    logic        capture;
    logic        trap;

    assign mem_ready = reset_n;
    assign capture   = mem_valid & mem_ready;

    // Upstream fault outranks a CSR access error.
    assign trap = valid_q & (exc_q | (csr_en_q & csr_error));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd_q        <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            cause_q     <= '0;
            tval_q      <= '0;
            csr_en_q    <= 1'b0;
            csr_op_q    <= '0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // The entry arriving on the trap edge is younger: drop it.
            valid_q <= capture & (state_q == RUN) & ~trap;
            if (capture) begin
                pc_q        <= mem_pc;
                rd_q        <= mem_rd;
                result_q    <= mem_result;
                exc_q       <= mem_exc;
                cause_q     <= mem_exc_cause;
                tval_q      <= mem_tval;
                csr_en_q    <= mem_csr_en;
                csr_op_q    <= mem_csr_op;
                csr_addr_q  <= mem_csr_addr;
                csr_wdata_q <= mem_csr_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (trap) begin
                    state_d = KILL;
                    cnt_d   = KILL_N;
                end
            end
            KILL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign csr_addr     = csr_addr_q;
    assign csr_wdata    = csr_wdata_q;
    // Faulted instructions must not side-effect the CSR file.
    assign csr_write    = (valid_q & ~exc_q & csr_en_q) ? csr_op_q : 2'b00;

    assign wb_exc       = trap;
    assign flush        = trap;
    assign wb_exc_cause = exc_q ? cause_q : ILLEGAL;
    assign wb_valid     = valid_q & ~trap;
    assign wb_pc        = pc_q;
    assign wb_data      = tval_q;

    assign rf_we        = valid_q & ~trap & (rd_q != 5'd0);
    assign rf_rd        = rd_q;
    assign rf_wdata     = csr_en_q ? csr_rdata : result_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed and random checks of wb_commit against a transaction-level model
// of retire, trap and kill-window behaviour.
module tb_wb_commit;

    localparam int KILL = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_pc;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        mem_exc;
    logic [3:0]  mem_exc_cause;
    logic [31:0] mem_tval;
    logic        mem_csr_en;
    logic [1:0]  mem_csr_op;
    logic [11:0] mem_csr_addr;
    logic [31:0] mem_csr_wdata;
    logic [11:0] csr_addr;
    logic [1:0]  csr_write;
    logic [31:0] csr_wdata;
    logic        csr_error;
    logic [31:0] csr_rdata;
    logic        wb_valid;
    logic        wb_exc;
    logic [3:0]  wb_exc_cause;
    logic [29:0] wb_pc;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        flush;

    always #5 clk = ~clk;

    wb_commit #(.KILL_CYCLES(KILL)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_result(mem_result),
        .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause),
        .mem_tval(mem_tval), .mem_csr_en(mem_csr_en),
        .mem_csr_op(mem_csr_op), .mem_csr_addr(mem_csr_addr),
        .mem_csr_wdata(mem_csr_wdata),
        .csr_addr(csr_addr), .csr_write(csr_write),
        .csr_wdata(csr_wdata), .csr_error(csr_error),
        .csr_rdata(csr_rdata),
        .wb_valid(wb_valid), .wb_exc(wb_exc),
        .wb_exc_cause(wb_exc_cause), .wb_pc(wb_pc), .wb_data(wb_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .flush(flush)
    );

    typedef struct {
        logic [29:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        csr_en;
        logic [1:0]  op;
        logic [11:0] caddr;
        logic [31:0] cwd;
    } ent_t;

    // Model: the instruction sitting in writeback, and how many more
    // incoming entries are still to be thrown away after a trap.
    ent_t m;
    bit   m_valid = 0;
    int   discard = 0;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input logic [29:0] pc, input logic [4:0] rd,
                        input logic [31:0] res, input logic exc,
                        input logic [3:0] cause, input logic [31:0] tval,
                        input logic cen, input logic [1:0] op,
                        input logic [11:0] caddr, input logic [31:0] cwd);
        mem_valid     = 1'b1;
        mem_pc        = pc;
        mem_rd        = rd;
        mem_result    = res;
        mem_exc       = exc;
        mem_exc_cause = cause;
        mem_tval      = tval;
        mem_csr_en    = cen;
        mem_csr_op    = op;
        mem_csr_addr  = caddr;
        mem_csr_wdata = cwd;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
    endtask

    // Check current outputs against the model, then clock one edge.
    task automatic tick();
        bit          trap;
        bit          retire;
        logic [1:0]  ewrite;
        #1;
        trap   = m_valid && (m.exc || (m.csr_en && csr_error));
        retire = m_valid && !trap;
        ewrite = (m_valid && !m.exc && m.csr_en) ? m.op : 2'b00;
        chk("mem_ready", 32'(mem_ready), 32'(reset_n));
        chk("wb_exc", 32'(wb_exc), 32'(trap));
        chk("flush", 32'(flush), 32'(trap));
        chk("wb_valid", 32'(wb_valid), 32'(retire));
        chk("rf_we", 32'(rf_we), 32'(retire && m.rd != 0));
        chk("csr_write", 32'(csr_write), 32'(ewrite));
        if (trap) begin
            chk("wb_exc_cause", 32'(wb_exc_cause),
                32'(m.exc ? m.cause : 4'd2));
        end
        if (m_valid) begin
            chk("wb_pc", 32'(wb_pc), 32'(m.pc));
            chk("wb_data", wb_data, m.tval);
            chk("rf_rd", 32'(rf_rd), 32'(m.rd));
            chk("csr_addr", 32'(csr_addr), 32'(m.caddr));
            chk("csr_wdata", csr_wdata, m.cwd);
        end
        if (retire && m.rd != 0) begin
            chk("rf_wdata", rf_wdata, m.csr_en ? csr_rdata : m.result);
        end
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 0;
            discard = 0;
        end else begin
            if (trap) begin
                discard = KILL;
                m_valid = 0;
            end else if (discard > 0) begin
                discard--;
                m_valid = 0;
            end else begin
                m_valid = mem_valid;
            end
            if (mem_valid) begin
                m.pc = mem_pc;  m.rd = mem_rd;  m.result = mem_result;
                m.exc = mem_exc;  m.cause = mem_exc_cause;
                m.tval = mem_tval;  m.csr_en = mem_csr_en;
                m.op = mem_csr_op;  m.caddr = mem_csr_addr;
                m.cwd = mem_csr_wdata;
            end
        end
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        csr_error = 1'b0;
        csr_rdata = 32'h0;
        send(30'h0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        idle();
        #1;
        chk("ready_in_reset", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_exc", 32'(wb_exc), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_wb_pc", 32'(wb_pc), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_csr_addr", 32'(csr_addr), 32'd0);
        tick();
        reset_n = 1'b1;

        // 1: plain ALU writeback
        send(30'h100, 5'd5, 32'h1234, 1'b0, 4'd0, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        tick();
        idle();
        #1;
        chk("t1_rf_we", 32'(rf_we), 32'd1);
        chk("t1_rf_rd", 32'(rf_rd), 32'd5);
        chk("t1_rf_wdata", rf_wdata, 32'h1234);
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_wb_exc", 32'(wb_exc), 32'd0);

        // 2: rd = x0 retires without a write
        send(30'h101, 5'd0, 32'hFFFF, 1'b0, 4'd0, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        tick();
        idle();
        #1;
        chk("t2_rf_we", 32'(rf_we), 32'd0);
        chk("t2_wb_valid", 32'(wb_valid), 32'd1);

        // 3: csrrs returns the pre-write CSR value
        send(30'h102, 5'd6, 32'hDEAD, 1'b0, 4'd0, 32'h0,
             1'b1, 2'b10, 12'h300, 32'h8);
        tick();
        idle();
        csr_rdata = 32'h1800;
        #1;
        chk("t3_csr_write", 32'(csr_write), 32'd2);
        chk("t3_csr_addr", 32'(csr_addr), 32'h300);
        chk("t3_rf_wdata", rf_wdata, 32'h1800);
        chk("t3_wb_exc", 32'(wb_exc), 32'd0);
        tick();

        // 4: read of an unimplemented CSR traps as illegal
        send(30'h103, 5'd7, 32'h0, 1'b0, 4'd0, 32'h7C0022F3,
             1'b1, 2'b00, 12'h7C0, 32'h0);
        tick();
        idle();
        csr_error = 1'b1;
        #1;
        chk("t4_wb_exc", 32'(wb_exc), 32'd1);
        chk("t4_cause", 32'(wb_exc_cause), 32'd2);
        chk("t4_wb_data", wb_data, 32'h7C0022F3);
        chk("t4_rf_we", 32'(rf_we), 32'd0);
        chk("t4_wb_valid", 32'(wb_valid), 32'd0);
        chk("t4_csr_write", 32'(csr_write), 32'd0);
        tick();
        csr_error = 1'b0;
        for (int i = 0; i < KILL; i++) tick();

        // 5: upstream fault beats the CSR op, then the kill window
        send(30'h104, 5'd8, 32'h0, 1'b1, 4'd5, 32'h1003,
             1'b1, 2'b01, 12'h305, 32'h55);
        tick();
        idle();
        #1;
        chk("t5_cause", 32'(wb_exc_cause), 32'd5);
        chk("t5_csr_write", 32'(csr_write), 32'd0);
        chk("t5_flush", 32'(flush), 32'd1);
        tick();
        for (int i = 0; i < KILL; i++) begin
            send(30'h200 + 30'(i), 5'd9, 32'h99, 1'b0, 4'd0, 32'h0,
                 1'b0, 2'b00, 12'h0, 32'h0);
            tick();
            chk("t5_killed_we", 32'(rf_we), 32'd0);
            chk("t5_killed_valid", 32'(wb_valid), 32'd0);
        end
        send(30'h210, 5'd10, 32'hABCD, 1'b0, 4'd0, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        tick();
        idle();
        #1;
        chk("t5_resume_we", 32'(rf_we), 32'd1);
        chk("t5_resume_wdata", rf_wdata, 32'hABCD);
        tick();

        // 6: reset in the middle of the kill window
        send(30'h300, 5'd1, 32'h0, 1'b1, 4'd4, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        send(30'h301, 5'd7, 32'h7777, 1'b0, 4'd0, 32'h0,
             1'b0, 2'b00, 12'h0, 32'h0);
        tick();
        idle();
        #1;
        chk("t6_rf_we", 32'(rf_we), 32'd1);
        chk("t6_rf_rd", 32'(rf_rd), 32'd7);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset_n   = ($urandom_range(0, 49) != 0);
            csr_error = ($urandom_range(0, 3) == 0);
            csr_rdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                send(30'($urandom), 5'($urandom), $urandom,
                     $urandom_range(0, 7) == 0, 4'($urandom), $urandom,
                     $urandom_range(0, 3) == 0, 2'($urandom),
                     12'($urandom), $urandom);
            end else begin
                idle();
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
